// File: rtl/accumulator_reg.sv
// Accumulator register with optional CF/ZF/NF/VF flags (ACC_FLAGS_EN); 1-cycle load latency.
// No backpressure: an LA=0 strobe always loads; ACC_BUS is combinational from REGA and EA.
module accumulator_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LA,
  input  logic             EA,
  input  logic             SU,
  input  logic             EU,
  input  logic [WIDTH-1:0] WBUS,
  input  logic [WIDTH-1:0] REGB,
  output logic [WIDTH-1:0] REGA,
  output logic [WIDTH-1:0] ACC_BUS,
  output logic             CF,
  output logic             ZF,
  output logic             NF,
  output logic             VF
);

  logic [WIDTH-1:0] acc;

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      acc <= '0;
    end else if (!LA) begin
      acc <= WBUS;
    end
  end

  assign REGA    = acc;
  assign ACC_BUS = EA ? acc : '0;

`ifdef ACC_FLAGS_EN
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           cf_nxt;
  logic           vf_nxt;
  logic           cf_q, zf_q, nf_q, vf_q;

  assign sum  = {1'b0, acc} + {1'b0, REGB};
  assign diff = {1'b0, acc} - {1'b0, REGB};

  // Bit WIDTH of the zero-extended difference is set exactly when A < B.
  always_comb begin
    cf_nxt = 1'b0;
    vf_nxt = 1'b0;
    if (SU) begin
      cf_nxt = diff[WIDTH];
      vf_nxt = (acc[WIDTH-1] != REGB[WIDTH-1]) && (diff[WIDTH-1] != acc[WIDTH-1]);
    end else begin
      cf_nxt = sum[WIDTH];
      vf_nxt = (acc[WIDTH-1] == REGB[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      cf_q <= 1'b0;
      zf_q <= 1'b0;
      nf_q <= 1'b0;
      vf_q <= 1'b0;
    end else if (!LA && EU) begin
      cf_q <= cf_nxt;
      zf_q <= (WBUS == '0);
      nf_q <= WBUS[WIDTH-1];
      vf_q <= vf_nxt;
    end
  end

  assign CF = cf_q;
  assign ZF = zf_q;
  assign NF = nf_q;
  assign VF = vf_q;
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{SU, EU, REGB};

  assign CF = 1'b0;
  assign ZF = 1'b0;
  assign NF = 1'b0;
  assign VF = 1'b0;
`endif

endmodule

// File: tb/tb_accumulator_reg.sv
// Directed self-checking bench for accumulator_reg; flag expectations follow ACC_FLAGS_EN.
module tb_accumulator_reg;

  logic       CLK = 1'b0;
  logic       CLR, LA, EA, SU, EU;
  logic [7:0] WBUS, REGB;
  logic [7:0] REGA, ACC_BUS;
  logic       CF, ZF, NF, VF;

  int checks   = 0;
  int failures = 0;

`ifdef ACC_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  accumulator_reg #(.WIDTH(8)) dut (
    .CLK(CLK), .CLR(CLR), .LA(LA), .EA(EA), .SU(SU), .EU(EU),
    .WBUS(WBUS), .REGB(REGB), .REGA(REGA), .ACC_BUS(ACC_BUS),
    .CF(CF), .ZF(ZF), .NF(NF), .VF(VF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Flags packed as {CF,ZF,NF,VF}; all-zero expectation when the flag logic is built out.
  function automatic logic [3:0] fl(input logic [3:0] f);
    return FLAGS_ON ? f : 4'b0000;
  endfunction

  task automatic edge_step(input logic clr, input logic la, input logic eu, input logic su,
                           input logic [7:0] wbus, input logic [7:0] regb);
    CLR = clr; LA = la; EU = eu; SU = su; WBUS = wbus; REGB = regb;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    CLR = 1'b0; LA = 1'b0; EA = 1'b1; SU = 1'b0; EU = 1'b0; WBUS = 8'hAA; REGB = 8'h00;

    // Reset overrides a pending load
    @(posedge CLK); #1;
    chk("rst_rega", REGA, 8'h00);
    chk("rst_flags", {CF, ZF, NF, VF}, 4'b0000);
    chk("rst_accbus_ea1", ACC_BUS, 8'h00);

    // Plain load with EU=0
    edge_step(1, 0, 0, 0, 8'h05, 8'h00);
    chk("load_05", REGA, 8'h05);
    edge_step(1, 0, 0, 0, 8'h3C, 8'h00);
    chk("load_3c", REGA, 8'h3C);
    chk("load_3c_flags", {CF, ZF, NF, VF}, 4'b0000);
    EA = 1'b1; #1;
    chk("accbus_ea1", ACC_BUS, 8'h3C);
    EA = 1'b0; #1;
    chk("accbus_ea0", ACC_BUS, 8'h00);

    // F0 + 20 = 110: carry out
    edge_step(1, 0, 0, 0, 8'hF0, 8'h00);
    edge_step(1, 0, 1, 0, 8'h10, 8'h20);
    chk("add_carry_rega", REGA, 8'h10);
    chk("add_carry_flags", {CF, ZF, NF, VF}, fl(4'b1000));

    // EU=0 load must hold flags
    edge_step(1, 0, 0, 0, 8'h7F, 8'h00);
    chk("eu0_hold_flags", {CF, ZF, NF, VF}, fl(4'b1000));

    // 7F + 01: signed overflow, negative
    edge_step(1, 0, 1, 0, 8'h80, 8'h01);
    chk("add_ovf_rega", REGA, 8'h80);
    chk("add_ovf_flags", {CF, ZF, NF, VF}, fl(4'b0011));

    // 03 - 03 = 0: zero, no borrow
    edge_step(1, 0, 0, 0, 8'h03, 8'h00);
    edge_step(1, 0, 1, 1, 8'h00, 8'h03);
    chk("sub_zero_flags", {CF, ZF, NF, VF}, fl(4'b0100));

    // 02 - 05: borrow, negative
    edge_step(1, 0, 0, 0, 8'h02, 8'h00);
    edge_step(1, 0, 1, 1, 8'hFD, 8'h05);
    chk("sub_borrow_rega", REGA, 8'hFD);
    chk("sub_borrow_flags", {CF, ZF, NF, VF}, fl(4'b1010));

    // LA=1 with EU=1: nothing changes
    edge_step(1, 1, 1, 0, 8'h55, 8'h01);
    chk("la1_hold_rega", REGA, 8'hFD);
    chk("la1_hold_flags", {CF, ZF, NF, VF}, fl(4'b1010));

    // 80 - 01 = 7F: signed overflow on subtract
    edge_step(1, 0, 0, 0, 8'h80, 8'h00);
    edge_step(1, 0, 1, 1, 8'h7F, 8'h01);
    chk("sub_ovf_rega", REGA, 8'h7F);
    chk("sub_ovf_flags", {CF, ZF, NF, VF}, fl(4'b0001));

    // Mid-sequence reset discards a simultaneous ALU load
    EA = 1'b1;
    edge_step(0, 0, 1, 0, 8'h77, 8'h90);
    chk("midrst_rega", REGA, 8'h00);
    chk("midrst_flags", {CF, ZF, NF, VF}, 4'b0000);
    chk("midrst_accbus", ACC_BUS, 8'h00);

    // LA, EA, EU together: bus shows old value until the edge
    edge_step(1, 0, 0, 0, 8'h11, 8'h00);
    CLR = 1'b1; LA = 1'b0; EA = 1'b1; EU = 1'b1; SU = 1'b0; WBUS = 8'h22; REGB = 8'h01;
    #1;
    chk("simul_pre_accbus", ACC_BUS, 8'h11);
    @(posedge CLK); #1;
    chk("simul_post_accbus", ACC_BUS, 8'h22);
    chk("simul_post_flags", {CF, ZF, NF, VF}, fl(4'b0000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accumulator_reg.md
ACCUMULATOR_REG -- requirements
Module: accumulator_reg

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 8, data path width in bits.
REQ-002 Port CLK SHALL be: CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 Port CLR SHALL be: CLR  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 Port LA SHALL be: LA  input  1  active-low load strobe; capture WBUS into accumulator.
REQ-005 Port EA SHALL be: EA  input  1  active-high output enable onto ACC_BUS.
REQ-006 Port SU SHALL be: SU  input  1  adder mode (0 add, 1 subtract), used for flag computation only.
REQ-007 Port EU SHALL be: EU  input  1  adder output enable; marks WBUS as carrying an ALU result.
REQ-008 Port WBUS SHALL be: WBUS  input  WIDTH  shared W-bus data.
REQ-009 Port REGB SHALL be: REGB  input  WIDTH  current B-register value.
REQ-010 Port REGA SHALL be: REGA  output  WIDTH  registered accumulator value, continuously driven to the adder/subtractor.
REQ-011 Port ACC_BUS SHALL be: ACC_BUS  output  WIDTH  accumulator bus drive; REGA when EA=1, else all zeros.
REQ-012 Ports CF, ZF, NF, VF SHALL be: each output 1, registered carry/borrow, zero, negative, signed-overflow flags.

Function
REQ-013 On a rising CLK edge with CLR=1 and LA=0, accumulator SHALL capture WBUS; REGA shows new value the same cycle after the edge (1-cycle latency).
REQ-014 With CLR=1 and LA=1, accumulator and all flags SHALL hold.
REQ-015 ACC_BUS SHALL be combinational from REGA and EA, no added latency; EA SHALL NOT affect stored state.
REQ-016 Flags SHALL update only on an edge where CLR=1, LA=0 and EU=1 (ALU-result load); LA=0 with EU=0 SHALL load accumulator and hold flags.
REQ-017 Flag arithmetic SHALL use pre-edge REGA (A) and REGB (B), zero-extended to WIDTH+1 bits.
REQ-018 SU=0: CF SHALL be bit WIDTH of A+B; VF SHALL be 1 when A[MSB]==B[MSB] and sum[MSB]!=A[MSB].
REQ-019 SU=1: CF SHALL be 1 when A<B unsigned (borrow); VF SHALL be 1 when A[MSB]!=B[MSB] and diff[MSB]!=A[MSB].
REQ-020 ZF SHALL be 1 when captured WBUS equals 0; NF SHALL equal captured WBUS[WIDTH-1].
REQ-021 Wrap-around: result wraps modulo 2^WIDTH in the accumulator; no saturation.
REQ-022 EU=1 with LA=1 SHALL change nothing (ALU result on bus not consumed).
REQ-023 LA, EA, EU asserted simultaneously SHALL be legal: load occurs, ACC_BUS shows old REGA until the edge.

Reset
REQ-024 Edge with CLR=0 SHALL set accumulator to 0 and CF, ZF, NF, VF to 0, overriding LA and EU.
REQ-025 Reset mid-sequence (CLR=0 on same edge as LA=0) SHALL discard the load; reset SHALL have no asynchronous path.
REQ-026 After reset, ACC_BUS SHALL be 0 regardless of EA.

Configuration
REQ-027 Macro ACC_FLAGS_EN SHALL control flag logic.
REQ-028 With ACC_FLAGS_EN defined, REQ-016..REQ-020 apply and flag registers are present.
REQ-029 Without ACC_FLAGS_EN, CF, ZF, NF, VF SHALL be constant 0, no flag registers or flag arithmetic synthesized; accumulator behaviour unchanged.

Verification
REQ-030 CLR=0 one edge with LA=0, WBUS=8'hAA -> REGA=0, flags 0, ACC_BUS=0 with EA=1.
REQ-031 A=8'h05, LA=0, EU=0, WBUS=8'h3C -> REGA=8'h3C, flags unchanged; EA=1 -> ACC_BUS=8'h3C, EA=0 -> 8'h00.
REQ-032 A=8'hF0, B=8'h20, SU=0, EU=1, LA=0, WBUS=8'h10 -> REGA=8'h10, CF=1, ZF=0, NF=0, VF=0.
REQ-033 A=8'h7F, B=8'h01, SU=0, EU=1, LA=0, WBUS=8'h80 -> CF=0, NF=1, VF=1; then A=8'h03, B=8'h03, SU=1, WBUS=8'h00 -> CF=0, ZF=1, VF=0.
REQ-034 A=8'h02, B=8'h05, SU=1, EU=1, LA=0, WBUS=8'hFD -> CF=1, NF=1, ZF=0, VF=0; next edge LA=1, EU=1 -> all hold.
REQ-035 Build without ACC_FLAGS_EN, repeat REQ-032 -> REGA=8'h10, CF=ZF=NF=VF=0.
